// File: rtl/max_pool1d.sv
// Streaming 1D max-pool: per-lane signed max over non-overlapping POOL_SIZE-beat windows,
// frames split on last. Define MAX_POOL1D_RELU_EN to clamp input lanes at zero (fused ReLU).
module max_pool1d #(
    parameter int unsigned VECTOR_SIZE = 1,
    parameter int unsigned POOL_SIZE   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i_n,
    input  logic [VECTOR_SIZE*8-1:0] data_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    output logic                     ready_o,
    output logic [VECTOR_SIZE*8-1:0] data_o,
    output logic                     valid_o,
    output logic                     last_o,
    input  logic                     ready_i
);

    localparam int unsigned CntW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(POOL_SIZE - 1);

    logic [CntW-1:0]          cnt_q;
    logic [VECTOR_SIZE*8-1:0] acc_q;
    logic [VECTOR_SIZE*8-1:0] data_q;
    logic                     valid_q;
    logic                     last_q;

    logic [VECTOR_SIZE*8-1:0] lane_in;
    logic [VECTOR_SIZE*8-1:0] max_d;
    logic                     in_fire;
    logic                     out_fire;
    logic                     win_done;

    // Single output register with no skid: accept only when it is empty or draining.
    assign ready_o  = !valid_q || ready_i;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_q && ready_i;
    assign win_done = in_fire && ((cnt_q == CntLast) || last_i);

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

    always_comb begin
        lane_in = data_i;
`ifdef MAX_POOL1D_RELU_EN
        for (int unsigned k = 0; k < VECTOR_SIZE; k++) begin
            if (data_i[8*k+7]) begin
                lane_in[8*k +: 8] = 8'h00;
            end
        end
`endif
        // First beat of a window seeds the max; later beats compare against the accumulator.
        max_d = lane_in;
        if (cnt_q != '0) begin
            for (int unsigned k = 0; k < VECTOR_SIZE; k++) begin
                if ($signed(acc_q[8*k +: 8]) > $signed(lane_in[8*k +: 8])) begin
                    max_d[8*k +: 8] = acc_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (win_done) begin
            data_q  <= max_d;
            valid_q <= 1'b1;
            last_q  <= last_i;
            cnt_q   <= '0;
        end else begin
            if (out_fire) begin
                valid_q <= 1'b0;
            end
            if (in_fire) begin
                acc_q <= max_d;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/max_pool1d.md
# max_pool1d

Streaming 1D max-pooling stage that sits directly downstream of the 1D convolution block in the wake-word datapath. It consumes the convolution output stream of signed 8-bit lanes, reduces each non-overlapping window of POOL_SIZE consecutive beats to its per-lane signed maximum, and forwards one beat per window. Frames are delimited by `last`; a partial window at frame end is flushed, never merged into the next frame.

## Interface
- `VECTOR_SIZE`, default 1: number of signed 8-bit lanes per beat.
- `POOL_SIZE`, default 2: window length and stride in beats, ≥1.
- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_i_n`  in  1  reset; asynchronous, active-low.
- `data_i`  in  VECTOR_SIZE*8  signed lanes, lane k at bits [8k+7:8k].
- `valid_i`  in  1  input beat valid.
- `last_i`  in  1  final beat of frame, qualified by `valid_i`.
- `ready_o`  out  1  block can accept a beat this cycle.
- `data_o`  out  VECTOR_SIZE*8  pooled signed lanes.
- `valid_o`  out  1  output beat valid.
- `last_o`  out  1  final pooled beat of frame.
- `ready_i`  in  1  downstream accepts output beat.

## Operation
- Input accept: `valid_i & ready_o`. Output transfer: `valid_o & ready_i`.
- `ready_o = !valid_o | ready_i` (combinational; one-entry output register, no skid).
- State: window counter `cnt` (0..POOL_SIZE-1), accumulator `acc` (VECTOR_SIZE*8), output register.
- On accepted beat x, per lane: m = (cnt==0) ? x : signed_max(acc, x).
  - If `cnt==POOL_SIZE-1` or `last_i`: load output register with m, `valid_o<=1`, `last_o<=last_i`, `cnt<=0`.
  - Else: `acc<=m`, `cnt<=cnt+1`.
- Comparison is two's-complement signed per lane; no width growth, no saturation.
- On output transfer with no new window completing same cycle: `valid_o<=0`. Transfer and new window completion in same cycle: output register reloaded, `valid_o` stays 1.
- `POOL_SIZE==1`: pure registered passthrough (every beat completes a window).
- Partial window at `last_i` (cnt < POOL_SIZE-1): emitted as max of beats received so far; next frame starts with `cnt==0`.
- `last_i` without `valid_i` is ignored.

## Timing
- Reset (async assert, sync-clean deassert): `valid_o=0`, `last_o=0`, `data_o=0`, `cnt=0`, `acc=0`; `ready_o=1` immediately.
- Latency: pooled beat visible on `valid_o`/`data_o` the cycle after the window-completing input beat is accepted.
- Throughput: one input beat per cycle while `ready_i` held high; output rate 1/POOL_SIZE.
- Backpressure: while `valid_o & !ready_i`, `ready_o=0`; `data_o`, `last_o` held stable; `cnt`, `acc` frozen.
- Reset mid-window or mid-output: partial window and pending output discarded; no beat emitted after reset.

## Configuration
- Macro `MAX_POOL1D_RELU_EN`.
- Defined: each input lane is clamped to max(x, 0) before the pooling compare; outputs are never negative (fused ReLU).
- Undefined: raw signed values pooled; negative maxima pass through unchanged.

## Test plan
- POOL_SIZE=2, VECTOR_SIZE=1, `ready_i=1`, beats 3, -5, 7, 2 (last on 2) -> outputs 3, 7 (last_o on 7), each one cycle after second beat of window.
- POOL_SIZE=2, beats -8, -3, -100 with last on -100 -> outputs -3, then -100 with last_o; next frame beats 1, 4 -> 4 (no carry-over).
- VECTOR_SIZE=2, POOL_SIZE=3, beats {lane1,lane0} = {10,-1}, {-2,5}, {4,127} -> single output {10,127}.
- Backpressure: hold `ready_i=0` with output pending -> `ready_o=0`, `data_o` stable for 5 cycles; release -> transfer, accept resumes same cycle, no beat lost or duplicated over 20-beat random frame vs. reference model.
- Reset asserted with cnt=1 and `valid_o=1` -> `valid_o=0` asynchronously; post-reset beats 6, 9 -> single output 9.
- `MAX_POOL1D_RELU_EN` defined: beats -4, -7 -> output 0; beats -2, 3 -> output 3.
